// File: rtl/ex_stage_if.sv
// Execute-stage bus bundle: decode-to-EX input, EX-to-MEM / EX-to-ID results,
// data SRAM request and the load-use / divider stall flags.
interface ex_stage_if;
  logic [178:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [103:0] ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         loading;
  logic         stallreq_for_ex;

  modport master (
    input  id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output loading, stallreq_for_ex
  );

  modport slave (
    output id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  loading, stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, single-cycle ALU, data SRAM request,
// one-cycle mult/multu and a restoring iterative divider that stalls the pipe.
//
// state  | meaning
// S_IDLE | no divide in progress; starts one when div/divu sits in EX
// S_RUN  | one restoring quotient step per cycle
// S_DONE | result on hi_i/lo_i with hilo_we=11 until EX advances
module ex_stage #(
  parameter int DIV_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  ex_stage_if.master io
);
  localparam int CW = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  logic [178:0] ex_r;
  logic [5:0]   hilo_bus;
  logic [13:0]  sl_bus;
  logic [31:0]  pc, inst, rdata1, rdata2;
  logic [11:0]  alu_op;
  logic [2:0]   sel_src1;
  logic [3:0]   sel_src2;
  logic         data_ram_en, rf_we, sel_rf_res;
  logic [3:0]   data_ram_wen;
  logic [4:0]   rf_waddr;

  always_ff @(posedge clk) begin
    if (rst)                       ex_r <= '0;
    else if (stall[2] && !stall[3]) ex_r <= '0;
    else if (!stall[2])            ex_r <= io.id_to_ex_bus;
  end

  assign {hilo_bus, sl_bus, pc, inst, alu_op, sel_src1, sel_src2, data_ram_en,
          data_ram_wen, rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = ex_r;

  logic [31:0] src1, src2, imm_sext, imm_zext, sra_res, ex_result;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & imm_sext)
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & imm_zext);

  assign sra_res = $signed(src2) >>> src1[4:0];

  assign ex_result = ({32{alu_op[11]}} & (src1 + src2))
                   | ({32{alu_op[10]}} & (src1 - src2))
                   | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                   | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  logic op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo, is_div;
  assign {op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo} = hilo_bus;
  assign is_div = op_div | op_divu;

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
  assign prod_u = {32'b0, rdata1} * {32'b0, rdata2};

  div_state_t  state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] rem_q, quo_q, dsr_q, a_abs, b_abs;
  logic        neg_q_q, neg_r_q;
  logic [32:0] shifted, diff;
  logic        ge;

  assign a_abs   = (op_div && rdata1[31]) ? -rdata1 : rdata1;
  assign b_abs   = (op_div && rdata2[31]) ? -rdata2 : rdata2;
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign ge      = shifted >= {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (is_div) begin
          cnt <= '0;
          if (rdata2 == 32'd0) begin
            // divide by zero: fixed all-ones quotient, raw dividend as remainder
            quo_q   <= '1;
            rem_q   <= rdata1;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end else begin
            quo_q   <= a_abs;
            rem_q   <= '0;
            dsr_q   <= b_abs;
            neg_q_q <= op_div & (rdata1[31] ^ rdata2[31]);
            neg_r_q <= op_div & rdata1[31];
          end
        end
        S_RUN: begin
          cnt   <= cnt + CW'(1);
          rem_q <= ge ? diff[31:0] : shifted[31:0];
          quo_q <= {quo_q[30:0], ge};
        end
        default: ;
      endcase
    end
  end

  logic        stallreq;
  logic [1:0]  hilo_we;
  logic [31:0] hi_i, lo_i;

  always_comb begin
    state_nx = state;
    stallreq = 1'b0;
    hilo_we  = 2'b00;
    hi_i     = '0;
    lo_i     = '0;
    case (state)
      S_IDLE: if (is_div) begin
        stallreq = 1'b1;
        state_nx = (rdata2 == 32'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        stallreq = 1'b1;
        if (cnt == CW'(DIV_STEPS - 1)) state_nx = S_DONE;
      end
      S_DONE: if (!stall[2]) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (state == S_DONE) begin
      hilo_we = 2'b11;
      hi_i    = neg_r_q ? -rem_q : rem_q;
      lo_i    = neg_q_q ? -quo_q : quo_q;
    end else if (op_mult) begin
      hilo_we = 2'b11;
      {hi_i, lo_i} = prod_s;
    end else if (op_multu) begin
      hilo_we = 2'b11;
      {hi_i, lo_i} = prod_u;
    end else if (op_mthi) begin
      hilo_we = 2'b10;
      hi_i    = rdata1;
    end else if (op_mtlo) begin
      hilo_we = 2'b01;
      lo_i    = rdata1;
    end
  end

  assign io.stallreq_for_ex = stallreq;
  assign io.data_sram_en    = data_ram_en & ~stallreq;
  assign io.data_sram_wen   = data_ram_wen & {4{io.data_sram_en}};
  assign io.data_sram_addr  = ex_result;
  assign io.data_sram_wdata = rdata2;
  assign io.loading         = sl_bus[13];

  assign io.ex_to_mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign io.ex_to_id_bus  = {hilo_we, hi_i, lo_i, rf_we, rf_waddr, ex_result};

  logic unused_bits;
  assign unused_bits = ^{sl_bus[12:0], inst[31:16], diff[32]};
endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: a driver issues decoded instructions,
// a monitor compares each one in EX against a behavioural reference model.
module tb_ex_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       force_en;
  logic [5:0] force_val;

  ex_stage_if ifc();
  assign stall = force_en ? force_val : {2'b00, {4{ifc.stallreq_for_ex}}};

  ex_stage #(.DIV_STEPS(32)) dut (.clk(clk), .rst(rst), .stall(stall), .io(ifc));

  always #5 clk = ~clk;

  typedef enum int {K_ADDU, K_SUBU, K_SLT, K_SLTU, K_AND, K_NOR, K_OR, K_XOR,
                    K_SLL, K_SRL, K_SRA, K_LUI, K_ADDIU, K_LW, K_SW, K_MULT,
                    K_MULTU, K_MTHI, K_MTLO, K_DIV, K_DIVU, K_BUBBLE} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] res;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf;
    logic [1:0]  hilo_we;
    logic [31:0] hi, lo;
    logic [31:0] wdata;
    logic        loading;
    int          stall_cycles;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Decode-side encoding of an instruction onto the ID/EX bus.
  function automatic logic [178:0] enc(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] pc, input logic [31:0] inst,
                                       input logic [4:0] waddr);
    logic [5:0] hb = '0; logic [13:0] sl = '0; logic [11:0] op = '0;
    logic [2:0] s1 = '0; logic [3:0] s2 = '0; logic en = 1'b0; logic [3:0] wen = '0;
    logic we = 1'b0; logic sr = 1'b0;
    case (k)
      K_ADDU:  begin op = 12'h800; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_SUBU:  begin op = 12'h400; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_SLT:   begin op = 12'h200; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_SLTU:  begin op = 12'h100; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_AND:   begin op = 12'h080; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_NOR:   begin op = 12'h040; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_OR:    begin op = 12'h020; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_XOR:   begin op = 12'h010; s1 = 3'b001; s2 = 4'b0001; we = 1'b1; end
      K_SLL:   begin op = 12'h008; s1 = 3'b100; s2 = 4'b0001; we = 1'b1; end
      K_SRL:   begin op = 12'h004; s1 = 3'b100; s2 = 4'b0001; we = 1'b1; end
      K_SRA:   begin op = 12'h002; s1 = 3'b100; s2 = 4'b0001; we = 1'b1; end
      K_LUI:   begin op = 12'h001; s2 = 4'b1000; we = 1'b1; end
      K_ADDIU: begin op = 12'h800; s1 = 3'b001; s2 = 4'b0010; we = 1'b1; end
      K_LW:    begin op = 12'h800; s1 = 3'b001; s2 = 4'b0010; we = 1'b1; sr = 1'b1;
                     en = 1'b1; sl[13] = 1'b1; end
      K_SW:    begin op = 12'h800; s1 = 3'b001; s2 = 4'b0010; en = 1'b1; wen = 4'hF;
                     sl[12] = 1'b1; end
      K_DIV:   hb = 6'b100000;
      K_DIVU:  hb = 6'b010000;
      K_MULT:  hb = 6'b001000;
      K_MULTU: hb = 6'b000100;
      K_MTHI:  hb = 6'b000010;
      K_MTLO:  hb = 6'b000001;
      default: ;
    endcase
    return {hb, sl, pc, inst, op, s1, s2, en, wen, we, waddr, sr, a, b};
  endfunction

  // Reference behaviour of each instruction in plain arithmetic.
  function automatic exp_t model(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [4:0] waddr);
    exp_t e;
    logic [4:0]  sa   = inst[10:6];
    logic [31:0] simm = {{16{inst[15]}}, inst[15:0]};
    longint      da, db, p;
    logic [63:0] pu;
    e.kind = k; e.res = '0; e.rf_we = 1'b0; e.waddr = waddr; e.pc = pc;
    e.ram_en = 1'b0; e.ram_wen = '0; e.sel_rf = 1'b0; e.hilo_we = 2'b00;
    e.hi = '0; e.lo = '0; e.wdata = b; e.loading = 1'b0; e.stall_cycles = 0;
    da = longint'($signed(a));
    db = longint'($signed(b));
    case (k)
      K_ADDU:  begin e.res = a + b; e.rf_we = 1'b1; end
      K_SUBU:  begin e.res = a - b; e.rf_we = 1'b1; end
      K_SLT:   begin e.res = (da < db) ? 32'd1 : 32'd0; e.rf_we = 1'b1; end
      K_SLTU:  begin e.res = (a < b) ? 32'd1 : 32'd0; e.rf_we = 1'b1; end
      K_AND:   begin e.res = a & b; e.rf_we = 1'b1; end
      K_NOR:   begin e.res = ~(a | b); e.rf_we = 1'b1; end
      K_OR:    begin e.res = a | b; e.rf_we = 1'b1; end
      K_XOR:   begin e.res = a ^ b; e.rf_we = 1'b1; end
      K_SLL:   begin e.res = b << sa; e.rf_we = 1'b1; end
      K_SRL:   begin e.res = b >> sa; e.rf_we = 1'b1; end
      K_SRA:   begin e.res = 32'(db >>> sa); e.rf_we = 1'b1; end
      K_LUI:   begin e.res = {inst[15:0], 16'h0}; e.rf_we = 1'b1; end
      K_ADDIU: begin e.res = a + simm; e.rf_we = 1'b1; end
      K_LW:    begin e.res = a + simm; e.rf_we = 1'b1; e.sel_rf = 1'b1;
                     e.ram_en = 1'b1; e.loading = 1'b1; end
      K_SW:    begin e.res = a + simm; e.ram_en = 1'b1; e.ram_wen = 4'hF; end
      K_MULT:  begin p = da * db; e.hilo_we = 2'b11; e.hi = p[63:32]; e.lo = p[31:0]; end
      K_MULTU: begin pu = 64'(a) * 64'(b); e.hilo_we = 2'b11; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      K_MTHI:  begin e.hilo_we = 2'b10; e.hi = a; end
      K_MTLO:  begin e.hilo_we = 2'b01; e.lo = a; end
      K_DIV, K_DIVU: begin
        e.hilo_we = 2'b11;
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.stall_cycles = 1;
        end else begin
          e.stall_cycles = 33;
          if (k == K_DIV) begin
            p = da / db;   e.lo = p[31:0];
            p = da % db;   e.hi = p[31:0];
          end else begin
            e.lo = a / b;  e.hi = a % b;
          end
        end
      end
      default: begin e.waddr = '0; e.pc = '0; e.wdata = '0; end
    endcase
    return e;
  endfunction

  task automatic issue(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] inst);
    int guard = 0;
    logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
    logic [4:0]  wa = 5'($urandom_range(1, 31));
    @(negedge clk);
    force_en = 1'b0;
    while (ifc.stallreq_for_ex && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: stallreq still 1 after %0d cycles, required 0", guard);
    end
    if (k == K_BUBBLE) begin
      ifc.id_to_ex_bus = enc(K_ADDU, a, b, pc, inst, wa);
      force_val = 6'b000110;
      force_en  = 1'b1;
    end else begin
      ifc.id_to_ex_bus = enc(k, a, b, pc, inst, wa);
    end
    @(posedge clk);
    #1;
    q.push_back(model(k, a, b, pc, inst, wa));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops one expectation per instruction that reaches EX.
  initial begin : monitor
    exp_t e;
    int   cyc;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.kind == K_DIV || e.kind == K_DIVU) begin
          cyc = 0;
          while (ifc.stallreq_for_ex && cyc < 100) begin
            cyc++;
            @(negedge clk);
          end
          chk("div_stall_cycles", 128'(cyc), 128'(e.stall_cycles));
          chk("div_hilo_we", 128'(ifc.ex_to_id_bus[103:102]), 128'(2'b11));
          chk("div_hi", 128'(ifc.ex_to_id_bus[101:70]), 128'(e.hi));
          chk("div_lo", 128'(ifc.ex_to_id_bus[69:38]), 128'(e.lo));
          chk("div_rf_we", 128'(ifc.ex_to_id_bus[37]), 128'(1'b0));
        end else if (e.kind == K_BUBBLE) begin
          chk("bubble_mem_bus", 128'(ifc.ex_to_mem_bus), 128'(0));
          chk("bubble_id_bus", 128'(ifc.ex_to_id_bus), 128'(0));
          chk("bubble_sram", 128'({ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr,
                                    ifc.data_sram_wdata, ifc.loading, ifc.stallreq_for_ex}), 128'(0));
        end else begin
          chk("mem_bus", 128'(ifc.ex_to_mem_bus),
              128'({e.pc, e.ram_en, e.ram_wen, e.sel_rf, e.rf_we, e.waddr, e.res}));
          chk("id_hilo_we", 128'(ifc.ex_to_id_bus[103:102]), 128'(e.hilo_we));
          if (e.hilo_we[1]) chk("id_hi", 128'(ifc.ex_to_id_bus[101:70]), 128'(e.hi));
          if (e.hilo_we[0]) chk("id_lo", 128'(ifc.ex_to_id_bus[69:38]), 128'(e.lo));
          chk("id_rf_result", 128'(ifc.ex_to_id_bus[37:0]), 128'({e.rf_we, e.waddr, e.res}));
          chk("sram_req", 128'({ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr,
                                ifc.data_sram_wdata}),
              128'({e.ram_en, e.ram_wen, e.res, e.wdata}));
          chk("loading_stallreq", 128'({ifc.loading, ifc.stallreq_for_ex}), 128'({e.loading, 1'b0}));
        end
      end
    end
  end

  initial begin : driver
    int    guard;
    bit    ok;
    kind_t k;
    force_en = 1'b0;
    force_val = '0;
    rst = 1'b1;
    ifc.id_to_ex_bus = enc(K_LW, 32'h1234, 32'h5678, 32'h400, 32'h0000_0010, 5'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_bus", 128'(ifc.ex_to_mem_bus), 128'(0));
    chk("reset_id_bus", 128'(ifc.ex_to_id_bus), 128'(0));
    chk("reset_flags", 128'({ifc.data_sram_en, ifc.loading, ifc.stallreq_for_ex}), 128'(0));
    rst = 1'b0;
    ifc.id_to_ex_bus = '0;

    issue(K_ADDU,  32'hFFFF_FFFF, 32'h1, 32'h0);
    issue(K_LW,    32'h1000, 32'h0, 32'h0000_FFFC);
    issue(K_SW,    32'h2000, 32'hDEAD_BEEF, 32'h0000_0004);
    issue(K_DIV,   32'hFFFF_FFF9, 32'h2, 32'h0);
    issue(K_DIVU,  32'h8000_0000, 32'h0, 32'h0);
    issue(K_MULT,  32'hFFFF_FFFE, 32'h3, 32'h0);
    issue(K_MULTU, 32'hFFFF_FFFE, 32'h3, 32'h0);
    issue(K_SRA,   32'h0, 32'h8000_0000, 32'h0000_07C0);
    issue(K_BUBBLE, 32'h55, 32'hAA, 32'h0);
    issue(K_MTHI,  32'hCAFE_0001, 32'h0, 32'h0);
    issue(K_MTLO,  32'hCAFE_0002, 32'h0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      k = kind_t'($urandom_range(0, 20));
      issue(k, pick(), pick(), $urandom);
    end

    @(negedge clk);
    force_en = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of a divide must abandon it without a HI/LO write.
    ifc.id_to_ex_bus = enc(K_DIV, 32'd100, 32'd7, 32'h800, 32'h0, 5'd0);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("run_stallreq", 128'(ifc.stallreq_for_ex), 128'(1'b1));
    rst = 1'b1;
    ifc.id_to_ex_bus = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_run_stallreq", 128'(ifc.stallreq_for_ex), 128'(1'b0));
    chk("rst_run_hilo_we", 128'(ifc.ex_to_id_bus[103:102]), 128'(2'b00));
    rst = 1'b0;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ifc.ex_to_id_bus[103:102] != 2'b00 || ifc.stallreq_for_ex) ok = 1'b0;
    end
    chk("rst_run_quiet_after", 128'(ok), 128'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
